// File: rtl/id_fwd_ctrl.sv
// ID-stage forwarding/hazard controller: tracks in-flight destinations per hart
// across DEPTH post-ID stages, picks the youngest producer, and flags load-use.
module id_fwd_stage_match #(
    parameter int HART_W     = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  v,
    input  logic [HART_W-1:0]     hart,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  id_valid,
    input  logic [HART_W-1:0]     id_hart,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [1:0]            src_reg_used,
    output logic                  m1,
    output logic                  m2
);
    logic hit;

    assign hit = id_valid & v & (hart == id_hart);
    assign m1  = hit & src_reg_used[0] & (rs1_addr != '0) & (rd == rs1_addr);
    assign m2  = hit & src_reg_used[1] & (rs2_addr != '0) & (rd == rs2_addr);
endmodule

module id_fwd_ctrl #(
    parameter  int NUM_HARTS  = 4,
    parameter  int DEPTH      = 3,
    parameter  int REG_ADDR_W = 5,
    localparam int HART_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    localparam int FWD_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [HART_W-1:0]     id_hart,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [1:0]            src_reg_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_gpr_we_,
    input  logic                  id_is_load,
    input  logic                  stall,
    input  logic [NUM_HARTS-1:0]  flush_hart,
    input  logic                  cnt_clr,
    output logic [FWD_W-1:0]      rs1_fwd_ctrl,
    output logic [FWD_W-1:0]      rs2_fwd_ctrl,
    output logic                  load_use_stall,
    output logic [31:0]           lu_stall_cnt
);
    typedef struct packed {
        logic                  v;
        logic [HART_W-1:0]     hart;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } ent_t;

    // tbl[0] is stage 1 (EX), tbl[DEPTH-1] is WB
    ent_t tbl [DEPTH];

    logic [DEPTH-1:0] m1, m2;
    logic [FWD_W-1:0] sel1, sel2;
    logic             ld1, ld2, lu1, lu2;
    logic             ins, e1_flush;
    ent_t             e1_out, id_ent;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        id_fwd_stage_match #(
            .HART_W     (HART_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .v            (tbl[g].v),
            .hart         (tbl[g].hart),
            .rd           (tbl[g].rd),
            .id_valid     (id_valid),
            .id_hart      (id_hart),
            .rs1_addr     (rs1_addr),
            .rs2_addr     (rs2_addr),
            .src_reg_used (src_reg_used),
            .m1           (m1[g]),
            .m2           (m2[g])
        );
    end

    // Walk oldest to youngest so the youngest producer overwrites the select
    always_comb begin
        sel1 = '0;
        ld1  = 1'b0;
        sel2 = '0;
        ld2  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m1[k]) begin
                sel1 = FWD_W'(k + 1);
                ld1  = tbl[k].ld;
            end
            if (m2[k]) begin
                sel2 = FWD_W'(k + 1);
                ld2  = tbl[k].ld;
            end
        end
    end

    assign lu1            = (sel1 == FWD_W'(1)) & ld1;
    assign lu2            = (sel2 == FWD_W'(1)) & ld2;
    assign load_use_stall = lu1 | lu2;
    assign rs1_fwd_ctrl   = lu1 ? '0 : sel1;
    assign rs2_fwd_ctrl   = lu2 ? '0 : sel2;

    assign ins = id_valid & ~id_gpr_we_ & (id_rd_addr != '0) & ~load_use_stall
               & ~flush_hart[id_hart];
    assign e1_flush = flush_hart[tbl[0].hart];

    always_comb begin
        id_ent   = '{v: ins, hart: id_hart, rd: id_rd_addr, ld: id_is_load};
        e1_out   = tbl[0];
        e1_out.v = tbl[0].v & ~e1_flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (!stall) begin
            tbl[0] <= id_ent;
            for (int k = 1; k < DEPTH; k++) tbl[k] <= (k == 1) ? e1_out : tbl[k-1];
        end else if (e1_flush) begin
            // flush beats freeze, but only the EX slot is exposed to it
            tbl[0].v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lu_stall_cnt <= '0;
        else if (cnt_clr)
            lu_stall_cnt <= '0;
        else if (load_use_stall && !stall && lu_stall_cnt != 32'hFFFF_FFFF)
            lu_stall_cnt <= lu_stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_id_fwd_ctrl.sv
// Directed bench for id_fwd_ctrl (4 harts, 3 stages); expectations hand-derived.
module tb_id_fwd_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [1:0]  id_hart;
    logic [4:0]  rs1_addr, rs2_addr, id_rd_addr;
    logic [1:0]  src_reg_used;
    logic        id_gpr_we_, id_is_load, stall, cnt_clr;
    logic [3:0]  flush_hart;
    logic [1:0]  rs1_fwd_ctrl, rs2_fwd_ctrl;
    logic        load_use_stall;
    logic [31:0] lu_stall_cnt;

    int total = 0;
    int fails = 0;

    id_fwd_ctrl #(.NUM_HARTS(4), .DEPTH(3), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_hart        (id_hart),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .src_reg_used   (src_reg_used),
        .id_rd_addr     (id_rd_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_is_load     (id_is_load),
        .stall          (stall),
        .flush_hart     (flush_hart),
        .cnt_clr        (cnt_clr),
        .rs1_fwd_ctrl   (rs1_fwd_ctrl),
        .rs2_fwd_ctrl   (rs2_fwd_ctrl),
        .load_use_stall (load_use_stall),
        .lu_stall_cnt   (lu_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] h, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [1:0] used, input logic [4:0] rd,
                         input logic we_, input logic ld);
        id_valid = v; id_hart = h; rs1_addr = r1; rs2_addr = r2;
        src_reg_used = used; id_rd_addr = rd; id_gpr_we_ = we_; id_is_load = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
    endtask

    // advance past the next rising edge, landing mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    // load x3 in hart 0, then reader of x3 held through the stall cycle
    task automatic load_use_seq(input logic clr);
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd3, 1'b0, 1'b1);
        tick();
        cnt_clr = clr;
        drive(1'b1, 2'd0, 5'd3, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        tick();
        cnt_clr = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush_hart = 4'b0; cnt_clr = 1'b0;
        drive(1'b1, 2'd0, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_fwd1", 32'(rs1_fwd_ctrl), 32'd0);
        chk("reset_lu", 32'(load_use_stall), 32'd0);
        chk("reset_cnt", lu_stall_cnt, 32'd0);
        idle();
        reset = 1'b1;
        tick();

        // EX/MEM/WB forward of x5
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("fwd_ex", 32'(rs1_fwd_ctrl), 32'd1);
        tick();
        chk("fwd_mem", 32'(rs1_fwd_ctrl), 32'd2);
        tick();
        chk("fwd_wb", 32'(rs1_fwd_ctrl), 32'd3);
        tick();
        chk("fwd_gone", 32'(rs1_fwd_ctrl), 32'd0);
        drain();

        // youngest wins on rs2
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 5'd0, 5'd7, 2'b10, 5'd0, 1'b1, 1'b0);
        chk("young_rs2", 32'(rs2_fwd_ctrl), 32'd1);
        chk("young_rs1_unused", 32'(rs1_fwd_ctrl), 32'd0);
        drain();

        // x0 is never forwarded
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0);
        chk("x0_rs1", 32'(rs1_fwd_ctrl), 32'd0);
        chk("x0_rs2", 32'(rs2_fwd_ctrl), 32'd0);
        drain();

        // load-use in hart 0
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'd0, 5'd3, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        chk("lu_fwd0", 32'(rs1_fwd_ctrl), 32'd0);
        tick();
        chk("lu_after_stall", 32'(load_use_stall), 32'd0);
        chk("lu_after_fwd2", 32'(rs1_fwd_ctrl), 32'd2);
        chk("lu_cnt1", lu_stall_cnt, 32'd1);
        drain();

        // load in hart 1, reader in hart 0
        drive(1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'd0, 5'd3, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("xhart_lu", 32'(load_use_stall), 32'd0);
        chk("xhart_fwd", 32'(rs1_fwd_ctrl), 32'd0);
        chk("xhart_cnt", lu_stall_cnt, 32'd1);
        drain();

        // flush during stall kills hart-2 producer in EX
        drive(1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        stall = 1'b1; flush_hart = 4'b0100;
        tick();
        stall = 1'b0; flush_hart = 4'b0000;
        drive(1'b1, 2'd2, 5'd9, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("flush_c0", 32'(rs1_fwd_ctrl), 32'd0);
        tick();
        chk("flush_c1", 32'(rs1_fwd_ctrl), 32'd0);
        tick();
        chk("flush_c2", 32'(rs1_fwd_ctrl), 32'd0);
        drain();

        // same with hart-1 producer: untouched, frozen in EX during stall
        drive(1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        stall = 1'b1; flush_hart = 4'b0100;
        tick();
        stall = 1'b0; flush_hart = 4'b0000;
        drive(1'b1, 2'd1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("noflush_ex", 32'(rs1_fwd_ctrl), 32'd1);
        tick();
        chk("noflush_mem", 32'(rs1_fwd_ctrl), 32'd2);
        drain();

        // saturation
        force dut.lu_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.lu_stall_cnt;
        #1;
        chk("sat_preload", lu_stall_cnt, 32'hFFFF_FFFE);
        load_use_seq(1'b0);
        chk("sat_first", lu_stall_cnt, 32'hFFFF_FFFF);
        load_use_seq(1'b0);
        load_use_seq(1'b0);
        chk("sat_hold", lu_stall_cnt, 32'hFFFF_FFFF);

        // clear beats increment
        load_use_seq(1'b1);
        chk("clr_cnt", lu_stall_cnt, 32'd0);

        // external stall during load-use does not count
        drain();
        drive(1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 5'd3, 1'b0, 1'b1);
        tick();
        stall = 1'b1;
        drive(1'b1, 2'd0, 5'd0, 5'd3, 2'b10, 5'd0, 1'b1, 1'b0);
        chk("stall_lu_rs2", 32'(load_use_stall), 32'd1);
        tick();
        chk("stall_cnt_hold", lu_stall_cnt, 32'd0);
        chk("stall_lu_still", 32'(load_use_stall), 32'd1);
        stall = 1'b0;
        tick();
        chk("stall_cnt_inc", lu_stall_cnt, 32'd1);
        chk("stall_rs2_fwd2", 32'(rs2_fwd_ctrl), 32'd2);
        drain();

        // asynchronous reset mid-operation
        drive(1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 5'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd3, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
        chk("arst_pre", 32'(rs1_fwd_ctrl), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_fwd", 32'(rs1_fwd_ctrl), 32'd0);
        chk("arst_cnt", lu_stall_cnt, 32'd0);
        reset = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
